// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO helpers: depth derivation and Gray/binary conversion
package fifo_pkg;

  // Widest pointer the helpers handle; narrower pointers are zero-extended in.
  localparam int unsigned MAXW = 32;

  function automatic int unsigned depth_of(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // Zero-extension is harmless: leading zeros map to leading zeros in both directions,
  // so one wide function serves every pointer width.
  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b = g;
    for (int i = 1; i < MAXW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin_conv.sv
// rtl/wptr_full_ctrl_gray2bin_conv.sv - combinational Gray-to-binary XOR-prefix converter
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic acc;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_o = '0;
    acc   = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-domain pointer, full/almost-full, level and overflow controller
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic                 clr_ovf,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic                 wen,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 wovf
);

  localparam int          PW          = ADDR_SIZE + 1;
  localparam int unsigned DEPTH       = depth_of(ADDR_SIZE);
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic          accept;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_match;

  gray2bin_conv #(.W(PW)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin_sync)
  );

  // Next pointers and status, all computed from the post-write pointer so that
  // full asserts on the same edge that accepts the last free slot.
  always_comb begin
    accept     = winc & ~wfull_q;
    wbin_d     = wbin_q + {{(PW-1){1'b0}}, accept};
    wgray_d    = PW'(bin2gray(MAXW'(wbin_d)));
    full_match = {~wq2_rptr[ADDR_SIZE -: 2], wq2_rptr[ADDR_SIZE-2:0]};
    wfull_d    = (wgray_d == full_match);
    wlevel_d   = wbin_d - rbin_sync;
    wafull_d   = (wlevel_d >= AFULL_LEVEL);
    wovf_d     = wovf_q;
    if (clr_ovf) begin
      wovf_d = 1'b0;
    end
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end
  end

  // Pointer and status registers; wptr leaves straight from its flop for the CDC path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  // Reset gates only the memory strobe; the state flops are already held by reset.
  assign wen          = accept & rst_n;
  assign waddr        = wbin_q[ADDR_SIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - randomized self-checking bench for wptr_full_ctrl
module tb_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic       clr_ovf;
  logic [4:0] wq2_rptr;
  logic [4:0] wptr;
  logic [3:0] waddr;
  logic       wen;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       wovf;

  wptr_full_ctrl #(.ADDR_SIZE(4), .AFULL_THRESH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .clr_ovf      (clr_ovf),
    .wq2_rptr     (wq2_rptr),
    .wptr         (wptr),
    .waddr        (waddr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: counts of items written and read, status derived arithmetically.
  int m_wcnt, m_rcnt, m_level;
  bit m_full, m_afull, m_ovf;
  bit e_wen, s_wen;
  int e_waddr;
  logic [3:0] s_waddr;
  logic [12:0] exp_v, dut_v;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt = 0; m_rcnt = 0; m_level = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic snap();
    exp_v = {gray5(m_wcnt), m_full, m_afull, 5'(m_level), m_ovf};
    dut_v = {wptr, wfull, walmost_full, wlevel, wovf};
  endtask

  // Drive one clock of stimulus, sample the pre-edge write strobe, advance the model.
  task automatic cycle(input bit w, input bit c, input int r);
    bit pre_full, acc;
    winc = w; clr_ovf = c; m_rcnt = r % 32; wq2_rptr = gray5(r);
    #1;
    s_wen = wen; s_waddr = waddr;
    e_wen = w && !m_full; e_waddr = m_wcnt % 16;
    @(posedge clk);
    pre_full = m_full;
    acc      = w && !m_full;
    m_wcnt   = (m_wcnt + int'(acc)) % 32;
    m_level  = (m_wcnt - m_rcnt + 64) % 32;
    m_full   = (m_level == 16);
    m_afull  = (m_level >= 14);
    if (w && pre_full) m_ovf = 1;
    else if (c)        m_ovf = 0;
    #1;
    snap();
  endtask

  task automatic test_reset();
    rst_n = 1; winc = 1; clr_ovf = 0; wq2_rptr = 0;
    #2 rst_n = 0;
    #1;
    model_reset(); snap();
    n_vec++; if (dut_v !== 13'd0) begin n_err++; $display("FAIL reset_async outs=%h want 0", dut_v); end
    n_vec++; if (wen !== 1'b0) begin n_err++; $display("FAIL reset_async wen=%b want 0", wen); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; snap();
      n_vec++; if (wen !== 1'b0) begin n_err++; $display("FAIL reset_hold wen=%b want 0", wen); end
      n_vec++; if (dut_v !== exp_v || waddr !== 4'd0) begin
        n_err++; $display("FAIL reset_hold outs=%h waddr=%h want %h/0", dut_v, waddr, exp_v); end
    end
    winc = 0;
    rst_n = 1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      cycle(1, 0, 0);
      n_vec++; if (s_wen !== e_wen || s_waddr !== 4'(e_waddr)) begin
        n_err++; $display("FAIL fill_wen k=%0d wen=%b waddr=%0d want %b/%0d", k, s_wen, s_waddr, e_wen, e_waddr); end
      n_vec++; if (dut_v !== exp_v) begin
        n_err++; $display("FAIL fill_outs k=%0d got=%h want=%h", k, dut_v, exp_v); end
    end
    n_vec++; if (wptr !== 5'b11000 || wlevel !== 5'd16 || wfull !== 1'b1) begin
      n_err++; $display("FAIL fill_end wptr=%b wlevel=%0d wfull=%b want 11000/16/1", wptr, wlevel, wfull); end
  endtask

  task automatic test_overflow();
    cycle(1, 0, 0);
    n_vec++; if (s_wen !== 1'b0) begin n_err++; $display("FAIL ovf_wen wen=%b want 0", s_wen); end
    n_vec++; if (dut_v !== exp_v || wptr !== 5'b11000 || wovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_set got=%h want=%h", dut_v, exp_v); end
    cycle(1, 1, 0);
    n_vec++; if (wovf !== 1'b1 || dut_v !== exp_v) begin
      n_err++; $display("FAIL ovf_set_wins wovf=%b want 1", wovf); end
    cycle(0, 1, 0);
    n_vec++; if (wovf !== 1'b0 || dut_v !== exp_v) begin
      n_err++; $display("FAIL ovf_clear wovf=%b want 0", wovf); end
  endtask

  task automatic test_drain_release();
    cycle(0, 0, 1);
    n_vec++; if (wfull !== 1'b0 || wlevel !== 5'd15 || walmost_full !== 1'b1 || dut_v !== exp_v) begin
      n_err++; $display("FAIL drain got=%h want=%h", dut_v, exp_v); end
  endtask

  task automatic test_wrap();
    int h1, h2;
    logic [4:0] prev;
    bit saw_wrap;
    cycle(0, 0, m_wcnt);
    h1 = m_wcnt; h2 = m_wcnt; prev = wptr; saw_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, h2);
      h2 = h1; h1 = m_wcnt;
      n_vec++; if ($countones(wptr ^ prev) != 1) begin
        n_err++; $display("FAIL wrap_onebit i=%0d prev=%b now=%b", i, prev, wptr); end
      n_vec++; if (dut_v !== exp_v || wfull !== 1'b0) begin
        n_err++; $display("FAIL wrap_outs i=%0d got=%h want=%h", i, dut_v, exp_v); end
      if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1;
      prev = wptr;
    end
    n_vec++; if (saw_wrap !== 1'b1) begin n_err++; $display("FAIL wrap_seen saw=%b want 1", saw_wrap); end
  endtask

  task automatic test_random();
    int r;
    r = m_rcnt;
    for (int i = 0; i < 300; i++) begin
      if (((m_wcnt - r + 64) % 32) > 0 && ($urandom % 3) == 0) r = (r + 1) % 32;
      cycle(($urandom % 4) != 0, ($urandom % 8) == 0, r);
      n_vec++; if (s_wen !== e_wen || s_waddr !== 4'(e_waddr)) begin
        n_err++; $display("FAIL rand_wen i=%0d wen=%b waddr=%0d want %b/%0d", i, s_wen, s_waddr, e_wen, e_waddr); end
      n_vec++; if (dut_v !== exp_v) begin
        n_err++; $display("FAIL rand_outs i=%0d got=%h want=%h", i, dut_v, exp_v); end
    end
  endtask

  task automatic test_reset_midop();
    int rf;
    cycle(0, 0, m_wcnt);
    rf = m_wcnt;
    for (int i = 0; i < 9; i++) cycle(1, 0, rf);
    n_vec++; if (wlevel !== 5'd9 || dut_v !== exp_v) begin
      n_err++; $display("FAIL midop_level wlevel=%0d want 9", wlevel); end
    #2 rst_n = 0;
    #1;
    model_reset(); snap();
    n_vec++; if (dut_v !== 13'd0 || waddr !== 4'd0 || wen !== 1'b0) begin
      n_err++; $display("FAIL midop_async outs=%h waddr=%h wen=%b want 0", dut_v, waddr, wen); end
    @(posedge clk); #1;
    winc = 0;
    rst_n = 1;
    cycle(1, 0, 0);
    n_vec++; if (s_waddr !== 4'd0 || s_wen !== 1'b1) begin
      n_err++; $display("FAIL midop_first waddr=%0d wen=%b want 0/1", s_waddr, s_wen); end
    n_vec++; if (dut_v !== exp_v || wptr !== 5'b00001) begin
      n_err++; $display("FAIL midop_after got=%h want=%h", dut_v, exp_v); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain_release();
    test_wrap();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
